// File: rtl/line_burst_adapter.sv
// Cache-line to memory-burst adapter: assembles fill lines from memory beats and
// serialises writeback lines into beats, with a one-cycle completion pulse.
module line_burst_adapter #(
  parameter int unsigned s_line   = 256,
  parameter int unsigned s_burst  = 64,
  parameter int unsigned s_offset = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               read_i,
  input  logic               write_i,
  input  logic [31:0]        address_i,
  input  logic [s_line-1:0]  line_i,
  output logic [s_line-1:0]  line_o,
  output logic               resp_o,
  input  logic [s_burst-1:0] burst_i,
  output logic [s_burst-1:0] burst_o,
  output logic [31:0]        address_o,
  output logic               read_o,
  output logic               write_o,
  input  logic               resp_i
);

  localparam int unsigned num_beats = s_line / s_burst;
  localparam int unsigned cnt_w     = (num_beats > 1) ? $clog2(num_beats) : 1;
  localparam logic [cnt_w-1:0] last_beat = cnt_w'(num_beats - 1);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t             state;
  logic [cnt_w-1:0]   cnt;
  logic [cnt_w-1:0]   cnt_inc;
  logic [s_line-1:0]  wb_buf;
  logic               unused_addr_bits;

  assign cnt_inc          = cnt + 1'b1;
  assign unused_addr_bits = ^address_i[s_offset-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      read_o    <= 1'b0;
      write_o   <= 1'b0;
      resp_o    <= 1'b0;
      address_o <= '0;
      line_o    <= '0;
      burst_o   <= '0;
      wb_buf    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (write_i || read_i) begin
            address_o <= {address_i[31:s_offset], {s_offset{1'b0}}};
            cnt       <= '0;
          end
          if (write_i) begin
            state   <= WR;
            write_o <= 1'b1;
            wb_buf  <= line_i;
            burst_o <= line_i[s_burst-1:0];
          end else if (read_i) begin
            state  <= RD;
            read_o <= 1'b1;
          end
        end
        RD: begin
          if (resp_i) begin
            line_o[s_burst*cnt +: s_burst] <= burst_i;
            if (cnt == last_beat) begin
              cnt    <= '0;
              state  <= DONE;
              read_o <= 1'b0;
              resp_o <= 1'b1;
            end else begin
              cnt <= cnt_inc;
            end
          end
        end
        WR: begin
          // burst_o is pre-loaded with the next beat so it is valid while waiting for resp_i
          if (resp_i) begin
            if (cnt == last_beat) begin
              cnt     <= '0;
              state   <= DONE;
              write_o <= 1'b0;
              resp_o  <= 1'b1;
              burst_o <= '0;
            end else begin
              cnt     <= cnt_inc;
              burst_o <= wb_buf[s_burst*cnt_inc +: s_burst];
            end
          end
        end
        DONE: begin
          resp_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_line_burst_adapter.sv
// Directed bench for line_burst_adapter: a beat-level reference model checked every
// cycle, plus literal expectations for the documented scenarios.
module tb_line_burst_adapter;

  localparam int unsigned LW = 256;
  localparam int unsigned BW = 64;
  localparam int unsigned NB = LW / BW;

  logic          clk = 1'b0;
  logic          rst, read_i, write_i, resp_i;
  logic [31:0]   address_i, address_o;
  logic [LW-1:0] line_i, line_o;
  logic [BW-1:0] burst_i, burst_o;
  logic          resp_o, read_o, write_o;

  always #5 clk = ~clk;

  line_burst_adapter #(.s_line(LW), .s_burst(BW), .s_offset(5)) dut (
    .clk(clk), .rst(rst), .read_i(read_i), .write_i(write_i),
    .address_i(address_i), .line_i(line_i), .line_o(line_o), .resp_o(resp_o),
    .burst_i(burst_i), .burst_o(burst_o), .address_o(address_o),
    .read_o(read_o), .write_o(write_o), .resp_i(resp_i)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) cyc++;

  // Reference model: a transfer is a count of beats still owed; fill beats land in a word array.
  logic [BW-1:0] m_line [NB];
  logic [BW-1:0] m_buf  [NB];
  logic [BW-1:0] m_burst;
  logic [31:0]   m_addr;
  logic          m_rd, m_wr, m_resp;
  bit            m_is_wr;
  int            m_left;
  int            idx;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NB; i++) begin m_line[i] = '0; m_buf[i] = '0; end
      m_burst = '0; m_addr = '0; m_rd = 0; m_wr = 0; m_resp = 0; m_left = 0; m_is_wr = 0;
    end else if (m_resp) begin
      m_resp = 0;
    end else if (m_left > 0) begin
      if (resp_i) begin
        idx = NB - m_left;
        if (!m_is_wr) m_line[idx] = burst_i;
        m_left--;
        if (m_left == 0) begin
          m_rd = 0; m_wr = 0; m_resp = 1; m_burst = '0;
        end else if (m_is_wr) begin
          m_burst = m_buf[NB - m_left];
        end
      end
    end else if (write_i) begin
      m_is_wr = 1; m_left = NB; m_wr = 1;
      for (int i = 0; i < NB; i++) m_buf[i] = line_i[BW*i +: BW];
      m_burst = m_buf[0];
      m_addr = {address_i[31:5], 5'b0};
    end else if (read_i) begin
      m_is_wr = 0; m_left = NB; m_rd = 1;
      m_addr = {address_i[31:5], 5'b0};
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("read_o",    read_o,    m_rd);
      check("write_o",   write_o,   m_wr);
      check("resp_o",    resp_o,    m_resp);
      check("address_o", address_o, m_addr);
      check("burst_o",   burst_o,   m_burst);
      check("line_o",    line_o,    {m_line[3], m_line[2], m_line[1], m_line[0]});
    end
  end

  // Activity monitor for the literal scenario checks
  int rd_cnt, wr_cnt, resp_cnt, resp_cyc, rd_rise, last_rise;
  logic rd_q = 1'b0;
  logic [BW-1:0] wr_beats[$];

  always @(negedge clk) begin
    if (read_o) rd_cnt++;
    if (read_o && !rd_q) begin rd_rise++; last_rise = cyc; end
    rd_q = read_o;
    if (write_o) begin wr_cnt++; wr_beats.push_back(burst_o); end
    if (resp_o) begin resp_cnt++; resp_cyc = cyc; end
  end

  task automatic clear_mon();
    rd_cnt = 0; wr_cnt = 0; resp_cnt = 0; resp_cyc = -1; rd_rise = 0; last_rise = -1;
    wr_beats.delete();
  endtask

  logic [LW-1:0] l037, l038, l040;
  logic [3:0]    nib;
  int            start;

  initial begin
    l037 = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
    l038 = {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}};
    l040 = {{8{8'h04}}, {8{8'h03}}, {8{8'h02}}, {8{8'h01}}};
    rst = 1; read_i = 0; write_i = 0; resp_i = 0;
    address_i = '0; line_i = '0; burst_i = '0;
    clear_mon();
    tick(); tick();
    chk_en = 1'b1;
    check("rst_line",  line_o, '0);
    check("rst_addr",  address_o, '0);
    check("rst_flags", {read_o, write_o, resp_o}, '0);
    rst = 0;
    tick();

    // Back-to-back read fill
    clear_mon(); start = cyc;
    read_i = 1; address_i = 32'h0000_1234; tick();
    read_i = 0; resp_i = 1;
    burst_i = {16{4'h1}}; tick();
    burst_i = {16{4'h2}}; tick();
    burst_i = {16{4'h3}}; tick();
    burst_i = {16{4'h4}}; tick();
    resp_i = 0; burst_i = '0; tick(); tick();
    check("rd_line",       line_o, l037);
    check("rd_model_line", {m_line[3], m_line[2], m_line[1], m_line[0]}, l037);
    check("rd_addr",       address_o, 32'h0000_1220);
    check("rd_read_cycles", rd_cnt, 4);
    check("rd_resp_count", resp_cnt, 1);
    check("rd_resp_time",  resp_cyc, start + 5);

    // Writeback with resp_i on alternate cycles
    clear_mon();
    line_i = l038; write_i = 1; address_i = 32'h0000_ABCD; tick();
    write_i = 0; line_i = '0;
    for (int i = 0; i < 8; i++) begin
      resp_i = i[0]; burst_i = {16{4'hF}}; tick();
    end
    resp_i = 0; burst_i = '0; tick(); tick();
    check("wr_write_cycles", wr_cnt, 8);
    check("wr_resp_count",   resp_cnt, 1);
    check("wr_line_kept",    line_o, l037);
    check("wr_addr",         address_o, 32'h0000_ABC0);
    check("wr_beat_count",   wr_beats.size(), 8);
    for (int i = 0; i < 8 && i < wr_beats.size(); i++) begin
      nib = 4'hA + 4'(i / 2);
      check("wr_beat_seq", wr_beats[i], {16{nib}});
    end

    // Simultaneous read and write: write wins
    clear_mon();
    line_i = {4{64'h0123_4567_89AB_CDEF}}; read_i = 1; write_i = 1; address_i = 32'h0000_0300; tick();
    read_i = 0; write_i = 0; resp_i = 1;
    for (int i = 0; i < 4; i++) begin burst_i = {8{8'(8'h90 + i)}}; tick(); end
    resp_i = 0; tick(); tick();
    check("both_read_cycles",  rd_cnt, 0);
    check("both_write_cycles", wr_cnt, 4);
    check("both_resp_count",   resp_cnt, 1);
    check("both_line_kept",    line_o, l037);

    // Reset mid-fill, then a clean fill
    clear_mon();
    read_i = 1; address_i = 32'hFFFF_5678; tick();
    read_i = 0; resp_i = 1;
    burst_i = {16{4'h5}}; tick();
    burst_i = {16{4'h6}}; tick();
    rst = 1; burst_i = {16{4'h7}}; tick();
    rst = 0; resp_i = 0; burst_i = '0;
    check("mid_rst_line",  line_o, '0);
    check("mid_rst_addr",  address_o, '0);
    check("mid_rst_burst", burst_o, '0);
    check("mid_rst_flags", {read_o, write_o, resp_o}, '0);
    tick(); tick(); tick();
    check("mid_rst_no_resp", resp_cnt, 0);
    read_i = 1; address_i = 32'h0000_0040; tick();
    read_i = 0; resp_i = 1;
    for (int i = 1; i <= 4; i++) begin burst_i = {8{8'(i)}}; tick(); end
    resp_i = 0; burst_i = '0; tick(); tick();
    check("post_rst_line", line_o, l040);
    check("post_rst_resp", resp_cnt, 1);
    check("post_rst_addr", address_o, 32'h0000_0040);

    // Stray resp_i in IDLE, then read_i held through DONE
    clear_mon();
    resp_i = 1; burst_i = {16{4'hE}}; tick(); tick();
    resp_i = 0;
    check("idle_resp_flags", {read_o, write_o, resp_o}, '0);
    check("idle_resp_line",  line_o, l040);
    clear_mon(); start = cyc;
    read_i = 1; resp_i = 1; address_i = 32'h0000_0100;
    for (int i = 0; i < 7; i++) begin burst_i = {16{4'(i + 1)}}; tick(); end
    read_i = 0;
    for (int i = 0; i < 4; i++) begin burst_i = {16{4'(i + 8)}}; tick(); end
    resp_i = 0; burst_i = '0; tick(); tick();
    check("held_rd_rises",     rd_rise, 2);
    check("held_second_start", last_rise, start + 7);
    check("held_read_cycles",  rd_cnt, 8);
    check("held_resp_count",   resp_cnt, 2);
    check("held_resp_time",    resp_cyc, start + 11);
    check("held_line",         line_o, {{16{4'hB}}, {16{4'hA}}, {16{4'h9}}, {16{4'h8}}});

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
